// File: rtl/crc4_pkg.sv
// crc4_pkg: shared definitions for the CRC-4 (x^4+x+1) encoder/checker pair.
//   - widths of the data, CRC and codeword fields
//   - polynomial and LFSR start value
//   - checker FSM state encoding
//   - crc4_step(): folds the low nbits of 'bits' into the remainder, MSB first
package crc4_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CRC_W  = 4;
    localparam int unsigned CW_W   = 36;

    // x^4 + x + 1 with the implicit x^4 term dropped
    localparam logic [CRC_W-1:0] CRC4_POLY = 4'h3;
    localparam logic [CRC_W-1:0] CRC4_INIT = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Bits are taken from bits[nbits-1] down to bits[0]; anything above nbits is ignored.
    function automatic logic [CRC_W-1:0] crc4_step(
        input logic [CRC_W-1:0] lfsr,
        input logic [CW_W-1:0]  bits,
        input int               nbits
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = lfsr;
        for (int i = CW_W - 1; i >= 0; i--) begin
            if (i < nbits) begin
                fb = r[CRC_W-1] ^ bits[i];
                r  = {r[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & CRC4_POLY);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc4_lfsr_step.sv
// crc4_lfsr_step: combinational fold of BITS_PER_CYCLE codeword bits into the
// 4-bit CRC remainder, MSB (bits[BITS_PER_CYCLE-1]) first.
// Ports:
//   lfsr       in   current remainder
//   bits       in   next BITS_PER_CYCLE codeword bits
//   next_lfsr  out  remainder after folding those bits
module crc4_lfsr_step
    import crc4_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic [CRC_W-1:0]          lfsr,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [CRC_W-1:0]          next_lfsr
);

    assign next_lfsr = crc4_step(lfsr, CW_W'(bits), int'(BITS_PER_CYCLE));

endmodule

// File: rtl/crc4_checker.sv
// crc4_checker: receive-side CRC-4 check of a 36-bit codeword (32 data + 4 CRC).
// The whole codeword is divided through the LFSR, BITS_PER_CYCLE bits per clock;
// a zero remainder means the codeword is intact.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   codeword on d_in is valid
//   in_ready   out  block can accept a codeword (IDLE only)
//   d_in       in   codeword, [35:4] data, [3:0] CRC
//   out_valid  out  result is valid (DONE)
//   out_ready  in   consumer accepts the result
//   d_out      out  data field of the latched codeword, never modified
//   crc_err    out  nonzero remainder, qualified by out_valid
//   err_cnt    out  saturating count of failed codewords   (CRC4_ERR_STATS_EN only)
//   word_cnt   out  saturating count of checked codewords  (CRC4_ERR_STATS_EN only)
// Build option: define CRC4_ERR_STATS_EN to add the err_cnt/word_cnt counters.
module crc4_checker
    import crc4_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   d_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d_out,
    output logic              crc_err
`ifdef CRC4_ERR_STATS_EN
    ,
    output logic [15:0]       err_cnt,
    output logic [15:0]       word_cnt
`endif
);

    localparam int unsigned      NBEATS    = CW_W / BITS_PER_CYCLE;
    localparam int unsigned      CNT_W     = $clog2(CW_W + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_e             state_q, state_d;
    logic [CW_W-1:0]    sr_q, sr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CRC_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CRC_W-1:0]   lfsr_fold;

    crc4_lfsr_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .lfsr      (lfsr_q),
        .bits      (sr_q[CW_W-1 -: BITS_PER_CYCLE]),
        .next_lfsr (lfsr_fold)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        data_d    = data_q;
        lfsr_d    = lfsr_q;
        beat_d    = beat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_d    = d_in;
                    data_d  = d_in[CW_W-1:CRC_W];
                    lfsr_d  = CRC4_INIT;
                    beat_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                lfsr_d = lfsr_fold;
                sr_d   = sr_q << BITS_PER_CYCLE;
                // Counter stops at the last beat instead of wrapping.
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_q  <= '0;
            lfsr_q  <= CRC4_INIT;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            beat_q  <= beat_d;
        end
    end

    assign d_out   = data_q;
    assign crc_err = (state_q == DONE) && (lfsr_q != '0);

`ifdef CRC4_ERR_STATS_EN
    logic [15:0] err_cnt_q;
    logic [15:0] word_cnt_q;
    logic        out_hs;

    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else if (out_hs) begin
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (crc_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt  = err_cnt_q;
    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: doc/crc4_checker.md
# crc4_checker

Receive-side counterpart of the 32-bit/CRC-4 encoder. It accepts a 36-bit codeword (32-bit data plus 4-bit CRC), recomputes the CRC over the full codeword with a multi-bit-per-cycle LFSR, and returns the data with a pass/fail flag. It sits between the link/storage read path and the consumer, using a valid/ready handshake on both sides.

## Interface
- BITS_PER_CYCLE, 4, codeword bits folded into the LFSR per clock; legal values are 1, 2, 3, 4, 6, 9, 12, 18, 36.
- CLK  in  1  clock; the only clock in the block.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  codeword on D_IN is valid.
- IN_READY  out  1  block can accept a codeword.
- D_IN  in  36  codeword: [35:4] is data, [3:0] is CRC.
- OUT_VALID  out  1  result is valid.
- OUT_READY  in  1  consumer accepts the result.
- D_OUT  out  32  data field of the checked codeword.
- CRC_ERR  out  1  remainder was nonzero; qualified by OUT_VALID.
- ERR_CNT  out  16  count of failed codewords (CRC4_ERR_STATS_EN only).
- WORD_CNT  out  16  count of checked codewords (CRC4_ERR_STATS_EN only).

## Operation
- Polynomial: x^4+x+1. Initial LFSR value: 4'h0. MSB first. No reflection, no final XOR. Must match the encoder bit for bit.
- Check rule: divide all 36 codeword bits, MSB first, through the LFSR. A remainder of 4'h0 means pass; anything else sets CRC_ERR=1.
- The FSM has three states:
  - IDLE: IN_READY=1. On IN_VALID&&IN_READY, latch D_IN into a shift register, clear the LFSR and the beat counter, then go to CALC.
  - CALC: each cycle, fold the top BITS_PER_CYCLE bits into the LFSR and shift. After N = 36/BITS_PER_CYCLE beats, go to DONE.
  - DONE: OUT_VALID=1. D_OUT and CRC_ERR are held stable. On OUT_READY, go to IDLE.
- Beat counter is sized $clog2(36+1) bits and is compared against N−1. It does not wrap.
- Data is never modified. D_OUT is always the latched D_IN[35:4], whether the check passes or fails.

## Timing
- Reset values: IN_READY=1 (state IDLE), OUT_VALID=0, D_OUT=0, CRC_ERR=0, ERR_CNT=0, WORD_CNT=0, LFSR=0.
- Latency: a codeword accepted at edge k produces OUT_VALID=1 from edge k+N. With the default, N=9.
- Throughput: one codeword per N+2 cycles when OUT_READY is held high (IDLE→CALC, N beats, DONE→IDLE).
- IN_READY is 0 throughout CALC and DONE. IN_VALID asserted during those states is ignored, and the source must hold it.
- OUT_READY=0 in DONE: stall indefinitely with the outputs frozen.
- OUT_READY=1 on the first DONE cycle: the handshake completes in that cycle. IN_READY returns the next cycle; a result and a new codeword are never accepted in the same cycle.
- RST mid-CALC or mid-DONE: abort on the next edge, drop the in-flight codeword, return to IDLE, clear all outputs. Counters clear too.
- IN_VALID and RST high together: RST wins and nothing is accepted.

## Configuration
- CRC4_ERR_STATS_EN defined:
  - WORD_CNT increments on every output handshake.
  - ERR_CNT increments on output handshakes where CRC_ERR=1.
  - Both counters saturate at 16'hFFFF and clear only on RST.
- CRC4_ERR_STATS_EN undefined: the ERR_CNT and WORD_CNT ports are absent and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package crc4_pkg holds:
  - CRC4_POLY = 4'h3 (x^4+x+1 without the x^4 term) and CRC4_INIT = 4'h0;
  - DATA_W = 32, CRC_W = 4, CW_W = 36;
  - the FSM state enum {IDLE, CALC, DONE};
  - function crc4_step(lfsr, bits, nbits), shared with the encoder.
- One sub-module, crc4_lfsr_step: combinational fold of BITS_PER_CYCLE bits into a 4-bit remainder, instantiated once.

## Test plan
- RST held 2 cycles at 250 MHz → IN_READY=1, OUT_VALID=0, CRC_ERR=0, D_OUT=0 on the first cycle after release.
- D_IN=36'h000000000, OUT_READY=1 → after 9 cycles OUT_VALID=1, D_OUT=32'h00000000, CRC_ERR=0.
- D_IN=36'hFFFFFFFF5 → D_OUT=32'hFFFFFFFF, CRC_ERR=0. Then D_IN=36'hFFFFFFFF4 (bit 0 flipped) → D_OUT=32'hFFFFFFFF, CRC_ERR=1. With the macro defined, ERR_CNT=1 and WORD_CNT=2.
- OUT_READY=0 for 20 cycles in DONE with IN_VALID=1 → OUT_VALID, D_OUT and CRC_ERR stay constant, IN_READY=0, no new accept. Raising OUT_READY → IN_READY=1 on the following cycle.
- RST pulsed for 1 cycle mid-CALC (beat 4) → the next cycle shows IDLE, IN_READY=1, and no OUT_VALID for the aborted codeword.
- Run BITS_PER_CYCLE=1 and =36 with the same vectors → identical D_OUT/CRC_ERR; latency is 36 cycles and 1 cycle respectively.
